// File: rtl/sort_pkt_arbiter.sv
// Packet-level round-robin arbiter in front of the packet sorter sink.
// Grants whole packets, caps each at MAX_PKT_LEN words and drops the overflow tail.
module sort_pkt_arbiter #(
    parameter int DWIDTH      = 16,
    parameter int MAX_PKT_LEN = 16,
    parameter int CH_NUM      = 2
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic [CH_NUM*DWIDTH-1:0]   snk_data_i,
    input  logic [CH_NUM-1:0]          snk_startofpacket_i,
    input  logic [CH_NUM-1:0]          snk_endofpacket_i,
    input  logic [CH_NUM-1:0]          snk_valid_i,
    output logic [CH_NUM-1:0]          snk_ready_o,
    output logic [DWIDTH-1:0]          src_data_o,
    output logic                       src_startofpacket_o,
    output logic                       src_endofpacket_o,
    output logic                       src_valid_o,
    input  logic                       src_ready_i,
    output logic [CH_NUM-1:0]          grant_o,
    output logic [CH_NUM-1:0]          trunc_o,
    input  logic [CH_NUM-1:0]          trunc_clr_i
);

    localparam int CW = $clog2(MAX_PKT_LEN) + 1;
    localparam int PW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PKT_LEN - 1);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_e;

    state_e            state_q, state_d;
    logic [CH_NUM-1:0] grant_q, grant_d;
    logic [CH_NUM-1:0] trunc_q, trunc_d;
    logic [PW-1:0]     last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [PW-1:0]     gIdx;
    logic [DWIDTH-1:0] gData;
    logic              gValid, gSop, gEop, cntLast;
    logic [PW-1:0]     pickIdx, tryIdx;
    logic              pickFound;
    logic [CH_NUM-1:0] truncSet;

    // Decode the one-hot grant into an index; with no grant this falls back to channel 0.
    always_comb begin
        gIdx  = '0;
        gData = snk_data_i[DWIDTH-1:0];
        for (int c = 0; c < CH_NUM; c++) begin
            if (grant_q[c]) begin
                gIdx = PW'(c);
            end
        end
        for (int c = 0; c < CH_NUM; c++) begin
            if (gIdx == PW'(c)) begin
                gData = snk_data_i[c*DWIDTH +: DWIDTH];
            end
        end
    end

    assign gValid  = snk_valid_i[gIdx];
    assign gSop    = snk_startofpacket_i[gIdx];
    assign gEop    = snk_endofpacket_i[gIdx];
    assign cntLast = (cnt_q == CNT_LAST);

    // Round-robin search starting just after the last served channel.
    always_comb begin
        pickFound = 1'b0;
        pickIdx   = '0;
        tryIdx    = '0;
        for (int off = 1; off <= CH_NUM; off++) begin
            tryIdx = PW'((int'(last_q) + off) % CH_NUM);
            if (!pickFound && snk_valid_i[tryIdx] && snk_startofpacket_i[tryIdx]) begin
                pickFound = 1'b1;
                pickIdx   = tryIdx;
            end
        end
    end

    always_comb begin
        state_d             = state_q;
        grant_d             = grant_q;
        last_d              = last_q;
        cnt_d               = cnt_q;
        truncSet            = '0;
        snk_ready_o         = '0;
        src_valid_o         = 1'b0;
        src_startofpacket_o = 1'b0;
        src_endofpacket_o   = 1'b0;
        case (state_q)
            IDLE: begin
                snk_ready_o = snk_valid_i & ~snk_startofpacket_i;
                if (pickFound) begin
                    grant_d          = '0;
                    grant_d[pickIdx] = 1'b1;
                    cnt_d            = '0;
                    state_d          = FWD;
                end
            end
            FWD: begin
                src_valid_o         = gValid;
                snk_ready_o[gIdx]   = src_ready_i;
                src_startofpacket_o = gSop && (cnt_q == '0);
                src_endofpacket_o   = gEop || cntLast;
                if (gValid && src_ready_i) begin
                    cnt_d = cnt_q + CW'(1);
                    if (gEop) begin
                        last_d  = gIdx;
                        grant_d = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (cntLast) begin
                        truncSet[gIdx] = 1'b1;
                        state_d        = DROP;
                    end
                end
            end
            DROP: begin
                snk_ready_o[gIdx] = 1'b1;
                if (gValid && gEop) begin
                    last_d  = gIdx;
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        // A new truncation takes priority over a clear in the same cycle.
        trunc_d = (trunc_q & ~trunc_clr_i) | truncSet;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            trunc_q <= '0;
            last_q  <= PW'(CH_NUM - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            trunc_q <= trunc_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign src_data_o = gData;
    assign grant_o    = grant_q;
    assign trunc_o    = trunc_q;

endmodule

// File: tb/tb_sort_pkt_arbiter.sv
// Directed testbench for sort_pkt_arbiter with hand-computed expectations.
// Each channel is driven by a small Avalon-ST source model that advances on ready.
module tb_sort_pkt_arbiter;

    localparam int DW  = 16;
    localparam int MPL = 16;
    localparam int CH  = 2;

    localparam logic [1:0]  RR_G [13] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                                          2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    localparam logic        RR_V [13] = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0};
    localparam logic        RR_S [13] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    localparam logic        RR_E [13] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    localparam logic [15:0] RR_D [13] = '{16'h0, 16'h0A01, 16'h0A02, 16'h0A03, 16'h0,
                                          16'h0B01, 16'h0B02, 16'h0B03, 16'h0,
                                          16'h0A04, 16'h0A05, 16'h0A06, 16'h0};
    localparam logic [1:0]  OR_R [5]  = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b00};
    localparam logic [1:0]  OR_G [5]  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00};

    logic              clk = 1'b0;
    logic              arst;
    logic [CH*DW-1:0]  snkData;
    logic [CH-1:0]     snkSop, snkEop, snkValid, snkReady;
    logic [DW-1:0]     srcData;
    logic              srcSop, srcEop, srcValid, srcReady;
    logic [CH-1:0]     grant, trunc, truncClr;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] pData [CH][64];
    logic          pSop  [CH][64];
    logic          pEop  [CH][64];
    int            pLen  [CH];
    int            pPos  [CH];

    sort_pkt_arbiter #(.DWIDTH(DW), .MAX_PKT_LEN(MPL), .CH_NUM(CH)) dut (
        .clk_i               (clk),
        .arst_i              (arst),
        .snk_data_i          (snkData),
        .snk_startofpacket_i (snkSop),
        .snk_endofpacket_i   (snkEop),
        .snk_valid_i         (snkValid),
        .snk_ready_o         (snkReady),
        .src_data_o          (srcData),
        .src_startofpacket_o (srcSop),
        .src_endofpacket_o   (srcEop),
        .src_valid_o         (srcValid),
        .src_ready_i         (srcReady),
        .grant_o             (grant),
        .trunc_o             (trunc),
        .trunc_clr_i         (truncClr)
    );

    always #5 clk = ~clk;

    // Hard stop in case something stalls the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clearChannels();
        for (int c = 0; c < CH; c++) begin
            pLen[c] = 0;
            pPos[c] = 0;
        end
    endtask

    task automatic loadWord(input int c, input logic [DW-1:0] d, input logic s, input logic e);
        pData[c][pLen[c]] = d;
        pSop[c][pLen[c]]  = s;
        pEop[c][pLen[c]]  = e;
        pLen[c]++;
    endtask

    // Drive every channel's current word plus sink ready/clear at the falling edge.
    task automatic applyStimulus(input logic rdy, input logic [CH-1:0] clr);
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            if (pPos[c] < pLen[c]) begin
                snkValid[c]           = 1'b1;
                snkSop[c]             = pSop[c][pPos[c]];
                snkEop[c]             = pEop[c][pPos[c]];
                snkData[c*DW +: DW]   = pData[c][pPos[c]];
            end else begin
                snkValid[c]           = 1'b0;
                snkSop[c]             = 1'b0;
                snkEop[c]             = 1'b0;
                snkData[c*DW +: DW]   = '0;
            end
        end
        srcReady = rdy;
        truncClr = clr;
        #1;
    endtask

    task automatic finishCycle();
        logic [CH-1:0] hs;
        hs = snkReady & snkValid;
        @(posedge clk);
        for (int c = 0; c < CH; c++) begin
            if (hs[c]) pPos[c]++;
        end
    endtask

    task automatic test_reset();
        arst     = 1'b1;
        snkValid = '0; snkSop = '0; snkEop = '0; snkData = '0;
        srcReady = 1'b1; truncClr = '0;
        clearChannels();
        @(negedge clk);
        #1;
        checks++; if (grant !== 2'b00) begin failures++; $display("[TB] FAIL reset_grant got=%b exp=00", grant); end
        checks++; if (trunc !== 2'b00) begin failures++; $display("[TB] FAIL reset_trunc got=%b exp=00", trunc); end
        checks++; if ({srcValid, srcSop, srcEop} !== 3'b000) begin failures++; $display("[TB] FAIL reset_src got=%b exp=000", {srcValid, srcSop, srcEop}); end
        checks++; if (snkReady !== 2'b00) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=00", snkReady); end
        snkValid = 2'b10;
        #1;
        checks++; if (snkReady !== 2'b10) begin failures++; $display("[TB] FAIL reset_orphan_ready got=%b exp=10", snkReady); end
        snkValid = '0;
        @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic test_round_robin();
        clearChannels();
        loadWord(0, 16'h0A01, 1, 0); loadWord(0, 16'h0A02, 0, 0); loadWord(0, 16'h0A03, 0, 1);
        loadWord(0, 16'h0A04, 1, 0); loadWord(0, 16'h0A05, 0, 0); loadWord(0, 16'h0A06, 0, 1);
        loadWord(1, 16'h0B01, 1, 0); loadWord(1, 16'h0B02, 0, 0); loadWord(1, 16'h0B03, 0, 1);
        for (int cyc = 0; cyc < 13; cyc++) begin
            applyStimulus(1'b1, '0);
            checks++; if (grant !== RR_G[cyc]) begin failures++; $display("[TB] FAIL rr_grant cyc=%0d got=%b exp=%b", cyc, grant, RR_G[cyc]); end
            checks++; if (srcValid !== RR_V[cyc]) begin failures++; $display("[TB] FAIL rr_valid cyc=%0d got=%b exp=%b", cyc, srcValid, RR_V[cyc]); end
            if (RR_V[cyc]) begin
                checks++; if (srcData !== RR_D[cyc]) begin failures++; $display("[TB] FAIL rr_data cyc=%0d got=%h exp=%h", cyc, srcData, RR_D[cyc]); end
                checks++; if ({srcSop, srcEop} !== {RR_S[cyc], RR_E[cyc]}) begin failures++; $display("[TB] FAIL rr_sop_eop cyc=%0d got=%b exp=%b", cyc, {srcSop, srcEop}, {RR_S[cyc], RR_E[cyc]}); end
            end
            finishCycle();
        end
    endtask

    task automatic test_truncation();
        int fwd;
        logic expV, expE, expR;
        logic [1:0] expT;
        fwd = 0;
        clearChannels();
        for (int i = 1; i <= 20; i++) loadWord(1, DW'(i), i == 1, i == 20);
        for (int cyc = 0; cyc < 22; cyc++) begin
            applyStimulus(1'b1, '0);
            expV = (cyc >= 1 && cyc <= 16);
            expE = (cyc == 16);
            expR = (cyc >= 1 && cyc <= 20);
            expT = (cyc >= 17) ? 2'b10 : 2'b00;
            checks++; if (srcValid !== expV) begin failures++; $display("[TB] FAIL tr_valid cyc=%0d got=%b exp=%b", cyc, srcValid, expV); end
            checks++; if (snkReady[1] !== expR) begin failures++; $display("[TB] FAIL tr_ready1 cyc=%0d got=%b exp=%b", cyc, snkReady[1], expR); end
            checks++; if (trunc !== expT) begin failures++; $display("[TB] FAIL tr_trunc cyc=%0d got=%b exp=%b", cyc, trunc, expT); end
            if (expV) begin
                checks++; if (srcData !== DW'(cyc)) begin failures++; $display("[TB] FAIL tr_data cyc=%0d got=%h exp=%h", cyc, srcData, DW'(cyc)); end
                checks++; if (srcEop !== expE) begin failures++; $display("[TB] FAIL tr_eop cyc=%0d got=%b exp=%b", cyc, srcEop, expE); end
                checks++; if (srcSop !== (cyc == 1)) begin failures++; $display("[TB] FAIL tr_sop cyc=%0d got=%b exp=%b", cyc, srcSop, cyc == 1); end
            end
            if (srcValid && srcReady) fwd++;
            finishCycle();
        end
        checks++; if (fwd != 16) begin failures++; $display("[TB] FAIL tr_fwd_count got=%0d exp=16", fwd); end
        checks++; if (pPos[1] != 20) begin failures++; $display("[TB] FAIL tr_accepted got=%0d exp=20", pPos[1]); end
        applyStimulus(1'b1, 2'b01);
        finishCycle();
        applyStimulus(1'b1, 2'b10);
        checks++; if (trunc !== 2'b10) begin failures++; $display("[TB] FAIL tr_clr_other got=%b exp=10", trunc); end
        finishCycle();
        applyStimulus(1'b1, 2'b00);
        checks++; if (trunc !== 2'b00) begin failures++; $display("[TB] FAIL tr_clr got=%b exp=00", trunc); end
        finishCycle();
    endtask

    task automatic test_backpressure();
        int xfers;
        logic rdy;
        logic [DW-1:0] expD;
        xfers = 0;
        clearChannels();
        for (int i = 1; i <= 4; i++) loadWord(0, 16'hC000 + DW'(i), i == 1, i == 4);
        for (int cyc = 0; cyc < 10; cyc++) begin
            rdy = (cyc % 2 == 0);
            applyStimulus(rdy, '0);
            if (cyc >= 1 && cyc <= 8) begin
                expD = 16'hC000 + DW'((cyc + 1) / 2);
                checks++; if (srcValid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid cyc=%0d got=%b exp=1", cyc, srcValid); end
                checks++; if (snkReady !== {1'b0, rdy}) begin failures++; $display("[TB] FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, snkReady, {1'b0, rdy}); end
                checks++; if (srcData !== expD) begin failures++; $display("[TB] FAIL bp_data cyc=%0d got=%h exp=%h", cyc, srcData, expD); end
                checks++; if ({srcSop, srcEop} !== {cyc <= 2, cyc >= 7}) begin failures++; $display("[TB] FAIL bp_sop_eop cyc=%0d got=%b exp=%b", cyc, {srcSop, srcEop}, {cyc <= 2, cyc >= 7}); end
            end else begin
                checks++; if (srcValid !== 1'b0) begin failures++; $display("[TB] FAIL bp_idle_valid cyc=%0d got=%b exp=0", cyc, srcValid); end
            end
            if (srcValid && srcReady) xfers++;
            finishCycle();
        end
        checks++; if (xfers != 4) begin failures++; $display("[TB] FAIL bp_xfers got=%0d exp=4", xfers); end
    endtask

    task automatic test_orphans_single();
        int xfers;
        xfers = 0;
        clearChannels();
        loadWord(1, 16'h1111, 0, 0);
        loadWord(1, 16'h2222, 0, 0);
        loadWord(1, 16'hABCD, 1, 1);
        for (int cyc = 0; cyc < 5; cyc++) begin
            applyStimulus(1'b1, '0);
            checks++; if (snkReady !== OR_R[cyc]) begin failures++; $display("[TB] FAIL or_ready cyc=%0d got=%b exp=%b", cyc, snkReady, OR_R[cyc]); end
            checks++; if (grant !== OR_G[cyc]) begin failures++; $display("[TB] FAIL or_grant cyc=%0d got=%b exp=%b", cyc, grant, OR_G[cyc]); end
            if (cyc == 3) begin
                checks++; if ({srcValid, srcSop, srcEop, srcData} !== {3'b111, 16'hABCD}) begin failures++; $display("[TB] FAIL or_single got=%b%b%b/%h exp=111/abcd", srcValid, srcSop, srcEop, srcData); end
            end
            if (srcValid && srcReady) xfers++;
            finishCycle();
        end
        checks++; if (xfers != 1) begin failures++; $display("[TB] FAIL or_xfers got=%0d exp=1", xfers); end
        clearChannels();
        loadWord(0, 16'hD001, 1, 0);
        loadWord(0, 16'hD002, 1, 0);
        loadWord(0, 16'hD003, 0, 1);
        for (int cyc = 0; cyc < 5; cyc++) begin
            applyStimulus(1'b1, '0);
            if (cyc >= 1 && cyc <= 3) begin
                checks++; if (srcData !== 16'hD000 + DW'(cyc)) begin failures++; $display("[TB] FAIL ms_data cyc=%0d got=%h exp=%h", cyc, srcData, 16'hD000 + DW'(cyc)); end
                checks++; if ({srcValid, srcSop, srcEop} !== {1'b1, cyc == 1, cyc == 3}) begin failures++; $display("[TB] FAIL ms_flags cyc=%0d got=%b exp=%b", cyc, {srcValid, srcSop, srcEop}, {1'b1, cyc == 1, cyc == 3}); end
            end
            finishCycle();
        end
    endtask

    task automatic test_async_reset();
        clearChannels();
        for (int i = 1; i <= 17; i++) loadWord(1, 16'h0100 + DW'(i), i == 1, i == 17);
        for (int i = 1; i <= 4; i++) loadWord(0, 16'hE000 + DW'(i), i == 1, i == 4);
        for (int cyc = 0; cyc < 20; cyc++) begin
            applyStimulus(1'b1, '0);
            if (cyc == 17) begin
                checks++; if (trunc !== 2'b10) begin failures++; $display("[TB] FAIL ar_pre_trunc got=%b exp=10", trunc); end
            end
            finishCycle();
        end
        applyStimulus(1'b1, '0);
        checks++; if ({srcValid, grant, srcData} !== {1'b1, 2'b01, 16'hE002}) begin failures++; $display("[TB] FAIL ar_word2 got=%b/%b/%h exp=1/01/e002", srcValid, grant, srcData); end
        #2;
        arst = 1'b1;
        #1;
        checks++; if ({srcValid, srcSop, srcEop} !== 3'b000) begin failures++; $display("[TB] FAIL ar_src got=%b exp=000", {srcValid, srcSop, srcEop}); end
        checks++; if (grant !== 2'b00) begin failures++; $display("[TB] FAIL ar_grant got=%b exp=00", grant); end
        checks++; if (trunc !== 2'b00) begin failures++; $display("[TB] FAIL ar_trunc got=%b exp=00", trunc); end
        clearChannels();
        snkValid = '0; snkSop = '0; snkEop = '0;
        @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        loadWord(0, 16'hF000, 1, 1);
        loadWord(1, 16'hF111, 1, 1);
        for (int cyc = 0; cyc < 4; cyc++) begin
            applyStimulus(1'b1, '0);
            if (cyc == 1) begin
                checks++; if ({grant, srcValid, srcData} !== {2'b01, 1'b1, 16'hF000}) begin failures++; $display("[TB] FAIL ar_first_win got=%b/%b/%h exp=01/1/f000", grant, srcValid, srcData); end
            end
            if (cyc == 3) begin
                checks++; if ({grant, srcValid, srcData} !== {2'b10, 1'b1, 16'hF111}) begin failures++; $display("[TB] FAIL ar_second_win got=%b/%b/%h exp=10/1/f111", grant, srcValid, srcData); end
            end
            finishCycle();
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_truncation();
        test_backpressure();
        test_orphans_single();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sort_pkt_arbiter.md
# sort_pkt_arbiter

Packet-level round-robin arbiter that shares the single Avalon-ST sink of the packet sorter between `CH_NUM` upstream requesters. Whole packets are granted atomically, each forwarded packet is capped at `MAX_PKT_LEN` words (forced end-of-packet plus tail drop), and the sorter's ready back-pressure is honoured. The block sits directly in front of the sorter, and its `src_*` port connects to the sorter's `snk_*` port.

## Interface
- `DWIDTH`, 16: data word width.
- `MAX_PKT_LEN`, 16: maximum words forwarded per packet; must match the sorter.
- `CH_NUM`, 2: number of requesters, ≥2.
- `clk_i` input 1: clock.
- `arst_i` input 1: reset, asynchronous, active-high.
- `snk_data_i` input `CH_NUM`×`DWIDTH`: per-channel data.
- `snk_startofpacket_i` input `CH_NUM`: per-channel start-of-packet.
- `snk_endofpacket_i` input `CH_NUM`: per-channel end-of-packet.
- `snk_valid_i` input `CH_NUM`: per-channel valid.
- `snk_ready_o` output `CH_NUM`: per-channel ready (ready latency 0).
- `src_data_o` output `DWIDTH`: data to sorter.
- `src_startofpacket_o` output 1: start-of-packet to sorter.
- `src_endofpacket_o` output 1: end-of-packet to sorter.
- `src_valid_o` output 1: valid to sorter.
- `src_ready_i` input 1: sorter ready.
- `grant_o` output `CH_NUM`: one-hot current grant; all zero when no channel is granted.
- `trunc_o` output `CH_NUM`: sticky per-channel truncation flag.
- `trunc_clr_i` input `CH_NUM`: per-channel clear for `trunc_o`.

## Operation
- The FSM has three states: IDLE, FWD and DROP. Registered state comprises the state, `grant_o`, the round-robin pointer `last`, the word counter `cnt` (`$clog2(MAX_PKT_LEN)+1` bits) and `trunc_o`.
- **IDLE**
  - Candidates are channels with `valid && sop`.
  - The search starts at `last+1` and wraps modulo `CH_NUM`. The first candidate found is registered into `grant_o`, `cnt` is set to 0, and the state moves to FWD.
  - Orphan words (`valid && !sop`) on any channel are dropped in IDLE: `snk_ready_o[c]=1` for those channels.
  - `src_valid_o=0` in IDLE.
- **FWD** (granted channel g)
  - The source outputs combinationally follow channel g: `src_data_o` = data[g], `src_valid_o` = valid[g], `snk_ready_o[g]` = `src_ready_i`.
  - `snk_ready_o` is 0 for every other channel.
  - `src_startofpacket_o` = sop[g] && `cnt==0`. A sop seen mid-packet is forwarded as 0.
  - On a transfer (`src_valid_o && src_ready_i`), `cnt` increments.
  - Transfer with eop[g]: `last<=g`, `grant_o<=0`, state goes to IDLE.
  - Transfer with `cnt==MAX_PKT_LEN-1` and no eop[g]:
    - `src_endofpacket_o` is forced to 1 on that word.
    - `trunc_o[g]` is set to 1.
    - State goes to DROP.
  - Otherwise `src_endofpacket_o` = eop[g].
- **DROP**
  - `snk_ready_o[g]=1`, `src_valid_o=0`, and the words are discarded.
  - On `valid[g] && eop[g]`: `last<=g`, `grant_o<=0`, state goes to IDLE.
- `trunc_o[c]` is cleared by `trunc_clr_i[c]`. If set and clear occur in the same cycle, set wins.
- A single-word packet (sop and eop on the same word) is forwarded normally, and `cnt` returns to IDLE value.

## Timing
- Reset values while `arst_i` is high:
  - State is IDLE.
  - `grant_o=0`, `trunc_o=0`, `snk_ready_o=0` except the IDLE orphan-drop rule.
  - `src_valid_o=0`, `src_startofpacket_o=0`, `src_endofpacket_o=0`, `src_data_o` = data of channel 0 (don't-care).
  - `last=CH_NUM-1`, so channel 0 has first priority.
- Arbitration takes 1 cycle. A sop presented in IDLE at cycle N appears on `src_*` from cycle N+1.
- Each packet boundary costs one IDLE bubble cycle.
- The data path has zero latency: a transfer happens in the same cycle as `valid[g] && src_ready_i`.
- `src_ready_i` low in FWD stalls channel g with no loss of data. The DROP state ignores `src_ready_i`.
- A request arriving at a non-granted channel while the grant is active waits, because its ready is held at 0.
- Reset asserted mid-packet aborts the packet immediately. The sorter sees `src_valid_o` fall without an eop, and the sorter is reset with the same reset net.

## Test plan
- **Round-robin:** ch0 and ch1 both hold 3-word packets at reset release. Required response: ch0 forwarded first, one IDLE cycle, then ch1, then ch0 again. `grant_o` sequence is 01, 00, 10, 00, 01.
- **Truncation:** with `MAX_PKT_LEN=16`, ch1 sends a 20-word packet (data 1..20). Required response:
  - 16 words are forwarded, with eop on word 16.
  - Words 17..20 are accepted and dropped.
  - `trunc_o=2'b10`.
  - Pulsing `trunc_clr_i[1]` returns `trunc_o` to 0.
- **Back-pressure:** `src_ready_i` toggles 1/0 every cycle during a 4-word ch0 packet. Required response: every word is delivered exactly once and in order, and `snk_ready_o[0]` mirrors `src_ready_i`.
- **Orphans, single-word packets, mid-packet sop:**
  - In IDLE, ch1 presents 2 valid words without sop, then a packet with sop and eop on one word (0xABCD). Required response: the orphans are dropped, then exactly one `src_*` word 0xABCD is forwarded with sop=1 and eop=1.
  - A sop asserted on word 2 of a forwarded packet appears as `src_startofpacket_o=0`.
- **Async reset:** assert `arst_i` between clock edges during word 2 of a packet. Required response:
  - `src_valid_o`, `grant_o` and `trunc_o` go to 0 immediately, without waiting for a clock edge.
  - After release, ch0 wins the first arbitration.
